nibbler_control: RTL and testbench
==================================

Name: nibbler_control

Overview:
- Fetch/execute sequencer for the Nibbler 4-bit datapath.
- Handshakes instruction fetch with program memory and decodes the 4-bit opcode from the external IR.
- Drives the ALU select, accumulator/flag/PC/memory/IO strobes, and holds the architectural C and Z flags.
- Sits between program ROM, data RAM, accumulator/ALU datapath and the PC unit.

Parameters:
- ALU_PASS_A, 3'd0, ALU select code: Y=A
- ALU_SUB, 3'd1, ALU select code: Y=A-B, C=borrow
- ALU_PASS_B, 3'd2, ALU select code: Y=B
- ALU_ADD, 3'd3, ALU select code: Y=A+B, C=carry-out
- ALU_NAND, 3'd4, ALU select code: Y=~(A&B)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  4  IR[7:4], valid from the cycle after ir_load
- imem_ack  in  1  program memory has instruction byte on bus
- dmem_ack  in  1  data RAM read/write complete
- alu_c  in  1  ALU carry/borrow
- alu_z  in  1  ALU zero
- imem_req  out  1  fetch request
- ir_load  out  1  IR capture strobe
- alu_sel  out  3  ALU S input
- b_src  out  2  ALU B mux: 0=immediate, 1=data RAM, 2=input port
- acc_we  out  1  accumulator write
- flags_we  out  1  internal C/Z update (also exported for debug)
- dmem_req  out  1  data RAM access request
- dmem_we  out  1  data RAM write (qualifies dmem_req)
- out_we  out  1  output port latch strobe
- pc_inc  out  1  PC+1
- pc_load  out  1  PC<=jump target
- c_flag  out  1  registered carry flag
- z_flag  out  1  registered zero flag

Behaviour:
- States: BOOT, FETCH, EXEC.
- Async reset (rst_n=0) forces BOOT and c_flag=z_flag=0. Takes effect immediately, including mid-fetch or mid-memory-wait; any pending handshake is abandoned.
- All strobes are combinational from state/opcode/acks and are 0 in BOOT. alu_sel=ALU_PASS_A and b_src=0 whenever not in an ALU opcode.
- BOOT: after reset release, 1 cycle, then go to FETCH.
- FETCH:
  - imem_req=1.
  - If imem_ack=0, hold.
  - If imem_ack=1: ir_load=1, pc_inc=1, and go to EXEC next edge.
- EXEC: decode opcode.
  - Register-only ops complete in 1 cycle.
  - Memory ops hold dmem_req=1 until dmem_ack=1. Their strobes (acc_we/flags_we/dmem_we) assert only in the dmem_ack cycle. Then go to FETCH.
- Opcode map (alu_sel/b_src, strobes):
  - 0 JC, 1 JNC, 2 JZ, 3 JNZ: pc_load=1 iff c_flag=1 / c_flag=0 / z_flag=1 / z_flag=0; otherwise pc_inc=1 to skip the address byte.
  - 4 JMP: pc_load=1 unconditionally.
  - 5 CMPI: SUB/imm, flags_we only.
  - 6 CMPM: SUB/RAM, flags_we only.
  - 7 LIT: PASS_B/imm, acc_we.
  - 8 IN: PASS_B/port, acc_we.
  - 9 OUT: out_we.
  - 10 ADDI: ADD/imm, acc_we+flags_we.
  - 11 ADDM: ADD/RAM, acc_we+flags_we.
  - 12 LD: PASS_B/RAM, acc_we.
  - 13 ST: PASS_A, dmem_req+dmem_we.
  - 14 NANDI: NAND/imm, acc_we+flags_we.
  - 15 NANDM: NAND/RAM, acc_we+flags_we.
- Flags: on the clock edge ending a cycle with flags_we=1, c_flag<=alu_c and z_flag<=alu_z. Otherwise both are held. Jumps test the registered flags, never alu_c/alu_z directly.
- Flag timing: an op's own flag update is visible to the very next instruction's EXEC.
- Exclusivity: pc_inc and pc_load are never both 1. acc_we is never 1 for CMPI/CMPM/ST/OUT/jumps.
- Acks: imem_ack outside FETCH and dmem_ack outside a memory op EXEC are ignored.
- Latency: minimum 2 cycles per instruction (1 FETCH + 1 EXEC), plus imem/dmem wait cycles.

Optional Feature:
- Macro: NIBBLER_SSTEP_EN.
- When defined:
  - Adds input port step (1 bit) and state STOP.
  - Every completed EXEC goes to STOP instead of FETCH.
  - STOP: all strobes 0, flags held. A rising edge of step (registered edge detect) moves STOP to FETCH.
  - Reset exits via BOOT to STOP, so the first instruction also requires a step.
- When undefined: no step port, no STOP state; behaviour as above.

Test Plan:
- Reset release, imem_ack tied 1 -> BOOT 1 cycle, then ir_load at cycle 2. c_flag=z_flag=0 throughout reset.
- FETCH with imem_ack delayed 3 cycles -> imem_req held 3 cycles. ir_load and pc_inc asserted exactly once, in the ack cycle.
- ADDI with alu_c=1, alu_z=0 -> alu_sel=3, b_src=0, acc_we=1, flags_we=1; next cycle c_flag=1. A following JC gives pc_load=1, pc_inc=0.
- CMPI with alu_z=1, alu_c=0, then JNZ -> acc_we=0 during CMPI, z_flag=1; JNZ gives pc_inc=1, pc_load=0.
- LD with dmem_ack after 2 cycles -> dmem_req high 3 cycles, acc_we only in the ack cycle. ST gives dmem_we=1 with alu_sel=0.
- rst_n pulsed low during a LD memory wait -> outputs 0 immediately, flags cleared, restart from BOOT. A stale dmem_ack in FETCH causes no strobe.

Source files
------------

// File: rtl/nibbler_control.sv
// nibbler_control: fetch/execute sequencer for the Nibbler 4-bit datapath.
//
// Handshakes instruction fetch with program memory, decodes the 4-bit opcode
// held in the external IR and drives ALU select, B-mux source and all
// accumulator/flag/PC/memory/IO strobes. Holds the architectural C and Z flags.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   i_opcode[3:0]     IR[7:4], valid from the cycle after o_ir_load
//   i_imem_ack        program memory byte available
//   i_dmem_ack        data RAM access complete
//   i_alu_c, i_alu_z  ALU carry/borrow and zero
//   i_step            single-step request (only with NIBBLER_SSTEP_EN)
//   o_imem_req        fetch request
//   o_ir_load         IR capture strobe
//   o_alu_sel[2:0]    ALU function select
//   o_b_src[1:0]      ALU B source: 0=immediate, 1=data RAM, 2=input port
//   o_acc_we          accumulator write
//   o_flags_we        C/Z update strobe (exported for debug)
//   o_dmem_req        data RAM request; o_dmem_we marks it as a write
//   o_out_we          output port latch strobe
//   o_pc_inc          PC+1
//   o_pc_load         PC <= jump target
//   o_c_flag, o_z_flag registered carry and zero flags
//
// Build option: define NIBBLER_SSTEP_EN to add the i_step port and a STOP
// state entered after every completed instruction (and after reset).

module nibbler_control #(
  parameter logic [2:0] ALU_PASS_A = 3'd0,
  parameter logic [2:0] ALU_SUB    = 3'd1,
  parameter logic [2:0] ALU_PASS_B = 3'd2,
  parameter logic [2:0] ALU_ADD    = 3'd3,
  parameter logic [2:0] ALU_NAND   = 3'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_opcode,
  input  logic       i_imem_ack,
  input  logic       i_dmem_ack,
  input  logic       i_alu_c,
  input  logic       i_alu_z,
`ifdef NIBBLER_SSTEP_EN
  input  logic       i_step,
`endif
  output logic       o_imem_req,
  output logic       o_ir_load,
  output logic [2:0] o_alu_sel,
  output logic [1:0] o_b_src,
  output logic       o_acc_we,
  output logic       o_flags_we,
  output logic       o_dmem_req,
  output logic       o_dmem_we,
  output logic       o_out_we,
  output logic       o_pc_inc,
  output logic       o_pc_load,
  output logic       o_c_flag,
  output logic       o_z_flag
);

`ifdef NIBBLER_SSTEP_EN
  typedef enum logic [1:0] {StBoot, StFetch, StExec, StStop} state_e;
`else
  typedef enum logic [1:0] {StBoot, StFetch, StExec} state_e;
`endif

  state_e r_state;
  logic   r_c_flag;
  logic   r_z_flag;
  logic   w_mem_op;
  logic   w_exec_done;
  logic   w_take;

  // Opcodes that touch data RAM: CMPM, ADDM, LD, ST, NANDM.
  always_comb begin
    unique case (i_opcode)
      4'd6, 4'd11, 4'd12, 4'd13, 4'd15: w_mem_op = 1'b1;
      default:                          w_mem_op = 1'b0;
    endcase
  end

  // Jump condition from the registered flags only.
  always_comb begin
    unique case (i_opcode)
      4'd0:    w_take = r_c_flag;
      4'd1:    w_take = ~r_c_flag;
      4'd2:    w_take = r_z_flag;
      4'd3:    w_take = ~r_z_flag;
      4'd4:    w_take = 1'b1;
      default: w_take = 1'b0;
    endcase
  end

  assign w_exec_done = ~w_mem_op | i_dmem_ack;

`ifdef NIBBLER_SSTEP_EN
  logic r_step;
  logic w_step_rise;
  assign w_step_rise = i_step & ~r_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_step <= 1'b0;
    else        r_step <= i_step;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StBoot;
      r_c_flag <= 1'b0;
      r_z_flag <= 1'b0;
    end else begin
      if (o_flags_we) begin
        r_c_flag <= i_alu_c;
        r_z_flag <= i_alu_z;
      end
      unique case (r_state)
`ifdef NIBBLER_SSTEP_EN
        StBoot:  r_state <= StStop;
        StExec:  if (w_exec_done) r_state <= StStop;
        StStop:  if (w_step_rise) r_state <= StFetch;
`else
        StBoot:  r_state <= StFetch;
        StExec:  if (w_exec_done) r_state <= StFetch;
`endif
        StFetch: if (i_imem_ack) r_state <= StExec;
        default: r_state <= StBoot;
      endcase
    end
  end

  always_comb begin
    o_imem_req = 1'b0;
    o_ir_load  = 1'b0;
    o_alu_sel  = ALU_PASS_A;
    o_b_src    = 2'd0;
    o_acc_we   = 1'b0;
    o_flags_we = 1'b0;
    o_dmem_req = 1'b0;
    o_dmem_we  = 1'b0;
    o_out_we   = 1'b0;
    o_pc_inc   = 1'b0;
    o_pc_load  = 1'b0;
    if (r_state == StFetch) begin
      o_imem_req = 1'b1;
      o_ir_load  = i_imem_ack;
      o_pc_inc   = i_imem_ack;
    end else if (r_state == StExec) begin
      o_dmem_req = w_mem_op;
      unique case (i_opcode)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
          o_pc_load = w_take;
          o_pc_inc  = ~w_take;
        end
        4'd5: begin
          o_alu_sel  = ALU_SUB;
          o_flags_we = 1'b1;
        end
        4'd6: begin
          o_alu_sel  = ALU_SUB;
          o_b_src    = 2'd1;
          o_flags_we = i_dmem_ack;
        end
        4'd7: begin
          o_alu_sel = ALU_PASS_B;
          o_acc_we  = 1'b1;
        end
        4'd8: begin
          o_alu_sel = ALU_PASS_B;
          o_b_src   = 2'd2;
          o_acc_we  = 1'b1;
        end
        4'd9: o_out_we = 1'b1;
        4'd10: begin
          o_alu_sel  = ALU_ADD;
          o_acc_we   = 1'b1;
          o_flags_we = 1'b1;
        end
        4'd11: begin
          o_alu_sel  = ALU_ADD;
          o_b_src    = 2'd1;
          o_acc_we   = i_dmem_ack;
          o_flags_we = i_dmem_ack;
        end
        4'd12: begin
          o_alu_sel = ALU_PASS_B;
          o_b_src   = 2'd1;
          o_acc_we  = i_dmem_ack;
        end
        4'd13: o_dmem_we = i_dmem_ack;
        4'd14: begin
          o_alu_sel  = ALU_NAND;
          o_acc_we   = 1'b1;
          o_flags_we = 1'b1;
        end
        default: begin
          o_alu_sel  = ALU_NAND;
          o_b_src    = 2'd1;
          o_acc_we   = i_dmem_ack;
          o_flags_we = i_dmem_ack;
        end
      endcase
    end
  end

  assign o_c_flag = r_c_flag;
  assign o_z_flag = r_z_flag;

endmodule

// File: tb/tb_nibbler_control.sv
// Testbench for nibbler_control (default build). Drives instruction sequences
// with random fetch/memory wait states and ALU results, and compares every
// cycle's outputs against an instruction-level reference model.

module tb_nibbler_control;

  logic       clk;
  logic       rst_n;
  logic [3:0] opcode;
  logic       imem_ack, dmem_ack, alu_c, alu_z;
  logic       imem_req, ir_load, acc_we, flags_we, dmem_req, dmem_we;
  logic       out_we, pc_inc, pc_load, c_flag, z_flag;
  logic [2:0] alu_sel;
  logic [1:0] b_src;
  logic [15:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: architectural flags.
  logic c_m, z_m;

  // Per-opcode attributes straight from the opcode map.
  int sel_tab [16] = '{0, 0, 0, 0, 0, 1, 1, 2, 2, 0, 3, 3, 2, 0, 4, 4};
  int bsr_tab [16] = '{0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 1, 1, 0, 0, 1};
  int acc_tab [16] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 0, 1, 1};
  int flg_tab [16] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 1, 1};
  int mem_tab [16] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1};

  nibbler_control u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_opcode   (opcode),
    .i_imem_ack (imem_ack),
    .i_dmem_ack (dmem_ack),
    .i_alu_c    (alu_c),
    .i_alu_z    (alu_z),
    .o_imem_req (imem_req),
    .o_ir_load  (ir_load),
    .o_alu_sel  (alu_sel),
    .o_b_src    (b_src),
    .o_acc_we   (acc_we),
    .o_flags_we (flags_we),
    .o_dmem_req (dmem_req),
    .o_dmem_we  (dmem_we),
    .o_out_we   (out_we),
    .o_pc_inc   (pc_inc),
    .o_pc_load  (pc_load),
    .o_c_flag   (c_flag),
    .o_z_flag   (z_flag)
  );

  assign obs = {imem_req, ir_load, alu_sel, b_src, acc_we, flags_we, dmem_req, dmem_we,
                out_we, pc_inc, pc_load, c_flag, z_flag};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] pack(input logic ireq, input logic irl, input int sel,
                                       input int bs, input logic acc, input logic fw,
                                       input logic dreq, input logic dwe, input logic ow,
                                       input logic pci, input logic pcl);
    logic [2:0] s3;
    logic [1:0] b2;
    s3 = 3'(sel);
    b2 = 2'(bs);
    return {ireq, irl, s3, b2, acc, fw, dreq, dwe, ow, pci, pcl, c_m, z_m};
  endfunction

  // Expected EXEC-cycle outputs; fin marks the completing cycle of the op.
  function automatic logic [15:0] exp_exec(input int op, input logic fin);
    logic take, jmp;
    jmp  = (op <= 4);
    take = (op == 0) ? c_m : (op == 1) ? !c_m : (op == 2) ? z_m : (op == 3) ? !z_m : (op == 4);
    return pack(1'b0, 1'b0, sel_tab[op], bsr_tab[op], fin && acc_tab[op] == 1,
                fin && flg_tab[op] == 1, mem_tab[op] == 1, fin && op == 13, op == 9,
                jmp && !take, jmp && take);
  endfunction

  task automatic tick_check(input string tag, input logic [15:0] exp);
    @(negedge clk);
    check_eq(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input int op, input int iw, input int dw, input logic ac,
                           input logic az);
    logic fw;
    for (int i = 0; i < iw; i++) begin
      imem_ack = 1'b0;
      dmem_ack = 1'($urandom);
      opcode   = 4'($urandom);
      {alu_c, alu_z} = 2'($urandom);
      tick_check("fetch_wait", pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    imem_ack = 1'b1;
    dmem_ack = 1'($urandom);
    opcode   = 4'($urandom);
    {alu_c, alu_z} = 2'($urandom);
    tick_check("fetch_ack", pack(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    opcode = 4'(op);
    if (mem_tab[op] == 1) begin
      for (int i = 0; i < dw; i++) begin
        dmem_ack = 1'b0;
        imem_ack = 1'($urandom);
        {alu_c, alu_z} = 2'($urandom);
        tick_check("mem_wait", exp_exec(op, 1'b0));
      end
      dmem_ack = 1'b1;
    end else begin
      dmem_ack = 1'($urandom);
    end
    imem_ack = 1'($urandom);
    alu_c = ac;
    alu_z = az;
    fw = (flg_tab[op] == 1);
    tick_check("exec", exp_exec(op, 1'b1));
    if (fw) begin
      c_m = ac;
      z_m = az;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 4'd0;
    imem_ack = 1'b1;
    dmem_ack = 1'b0;
    alu_c = 1'b0;
    alu_z = 1'b0;
    c_m = 1'b0;
    z_m = 1'b0;
    #3;
    check_eq("reset_hold", obs, 16'h0000);
    @(posedge clk);
    #1;
    check_eq("reset_hold2", obs, 16'h0000);
    rst_n = 1'b1;
    tick_check("boot", 16'h0000);

    // Directed sequence.
    run_instr(10, 0, 0, 1'b1, 1'b0);  // ADDI: C=1
    run_instr(0, 0, 0, 1'b0, 1'b0);   // JC taken
    run_instr(5, 3, 0, 1'b0, 1'b1);   // CMPI with 3-cycle fetch wait: Z=1
    run_instr(3, 0, 0, 1'b0, 1'b0);   // JNZ not taken
    run_instr(12, 0, 2, 1'b1, 1'b1);  // LD, 2 wait cycles
    run_instr(13, 0, 1, 1'b0, 1'b0);  // ST
    run_instr(14, 1, 0, 1'b1, 1'b1);  // NANDI: C=Z=1

    // Reset pulsed during a LD memory wait.
    imem_ack = 1'b1;
    tick_check("fetch_ack", pack(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    opcode   = 4'd12;
    dmem_ack = 1'b0;
    tick_check("mem_wait", exp_exec(12, 1'b0));
    #2;
    rst_n = 1'b0;
    c_m = 1'b0;
    z_m = 1'b0;
    #1;
    check_eq("rst_mid", obs, 16'h0000);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b1;
    tick_check("boot2", 16'h0000);
    tick_check("stale_dmem", pack(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Random instruction stream.
    for (int k = 0; k < 300; k++) begin
      run_instr(int'($urandom_range(15, 0)), int'($urandom_range(3, 0)),
                int'($urandom_range(3, 0)), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
